// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder result checker.
// Holds the state encoding, default sizes and overflow-mode encodings.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CW    = 8;

  localparam int OVF_UNSIGNED = 0;
  localparam int OVF_SIGNED   = 1;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_ref_pipe.sv
// Reference adder plus a LAT-deep valid/data shift register that delays the
// expected {overflow, sum} so it lines up with the adder's registered output.
module adder_ref_pipe
  import adder_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LAT      = 1,
  parameter int OVF_MODE = OVF_UNSIGNED
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_exp_sum,
  output logic             o_exp_ovf
);

  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_exp_sum;
  logic             w_exp_ovf;

  logic             r_valid [LAT];
  logic [WIDTH:0]   r_data  [LAT];

  assign w_full    = {1'b0, i_a} + {1'b0, i_b};
  assign w_exp_sum = w_full[WIDTH-1:0];
  assign w_exp_ovf = (OVF_MODE == OVF_SIGNED)
                   ? signed_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_exp_sum[WIDTH-1])
                   : w_full[WIDTH];

  // Flushing only drops the valids; stale data behind an invalid entry is never compared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < LAT; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      r_valid[0] <= i_push;
      r_data[0]  <= {w_exp_ovf, w_exp_sum};
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid   = r_valid[LAT-1];
  assign o_exp_sum = r_data[LAT-1][WIDTH-1:0];
  assign o_exp_ovf = r_data[LAT-1][WIDTH];

endmodule

// File: rtl/adder_checker.sv
// Scoreboard for an adder: compares the delayed reference result against the
// adder's Sum/Overflow, counts passes/errors and captures the first mismatch.
module adder_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LAT         = 1,
  parameter int OVF_MODE    = OVF_UNSIGNED,
  parameter int STOP_ON_ERR = 0,
  parameter int CW          = DEF_CW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_overflow,
  output logic             o_busy,
  output logic [CW-1:0]    o_pass_cnt,
  output logic [CW-1:0]    o_err_cnt,
  output logic             o_err_pulse,
  output logic             o_fail,
  output logic [WIDTH:0]   o_first_exp,
  output logic [WIDTH:0]   o_first_got
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t           r_state;
  state_t           w_next_state;

  logic             w_push;
  logic             w_pipe_valid;
  logic [WIDTH-1:0] w_pipe_sum;
  logic             w_pipe_ovf;
  logic [WIDTH:0]   w_exp;
  logic [WIDTH:0]   w_got;
  logic             w_compare;
  logic             w_match;
  logic             w_mismatch;

  logic [CW-1:0]    r_pass_cnt;
  logic [CW-1:0]    r_err_cnt;
  logic             r_err_pulse;
  logic             r_fail;
  logic [WIDTH:0]   r_first_exp;
  logic [WIDTH:0]   r_first_got;

  assign w_push = (r_state == ST_RUN) && i_en && !i_clr;

  adder_ref_pipe #(
    .WIDTH    (WIDTH),
    .LAT      (LAT),
    .OVF_MODE (OVF_MODE)
  ) u_ref_pipe (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_clr),
    .i_push    (w_push),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_valid   (w_pipe_valid),
    .o_exp_sum (w_pipe_sum),
    .o_exp_ovf (w_pipe_ovf)
  );

  // Entries still draining in IDLE/HALT are compared by nobody.
  assign w_exp      = {w_pipe_ovf, w_pipe_sum};
  assign w_got      = {i_overflow, i_sum};
  assign w_compare  = w_pipe_valid && (r_state == ST_RUN) && !i_clr;
  assign w_mismatch = w_compare && (w_got != w_exp);
  assign w_match    = w_compare && (w_got == w_exp);

  always_comb begin
    w_next_state = r_state;
    if (i_clr) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) w_next_state = ST_RUN;
        ST_RUN:  if (w_mismatch && (STOP_ON_ERR != 0)) w_next_state = ST_HALT;
        ST_HALT: w_next_state = ST_HALT;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
      r_fail      <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (i_clr) begin
      r_pass_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
      r_fail      <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else begin
      r_err_pulse <= w_mismatch;
      if (w_match && (r_pass_cnt != '1)) begin
        r_pass_cnt <= r_pass_cnt + CNT_ONE;
      end
      if (w_mismatch) begin
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + CNT_ONE;
        end
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_first_exp <= w_exp;
          r_first_got <= w_got;
        end
      end
    end
  end

  assign o_busy      = (r_state == ST_RUN);
  assign o_pass_cnt  = r_pass_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_err_pulse = r_err_pulse;
  assign o_fail      = r_fail;
  assign o_first_exp = r_first_exp;
  assign o_first_got = r_first_got;

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker: five checker configurations watch behavioural
// adders fed from shared stimulus, with error injection on the reported result.
module tb_adder_checker;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [3:0] injSum = '0;
  logic       injOvf = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural adders the checkers watch: LAT=1 unsigned, LAT=1 signed, LAT=2 unsigned.
  logic [4:0] full;
  logic       sgnOvf;
  logic [4:0] m1u = '0;
  logic [4:0] m1s = '0;
  logic [4:0] d1 = '0;
  logic [4:0] m2u = '0;

  assign full   = {1'b0, a} + {1'b0, b};
  assign sgnOvf = (a[3] == b[3]) && (full[3] != a[3]);

  always @(posedge clk) begin
    if (en) begin
      m1u <= full;
      m1s <= {sgnOvf, full[3:0]};
      d1  <= full;
    end
    m2u <= d1;
  end

  logic [3:0] sumU1, sumS1, sumU2;
  logic       ovfU1, ovfS1, ovfU2;
  assign sumU1 = m1u[3:0] ^ injSum;
  assign ovfU1 = m1u[4] ^ injOvf;
  assign sumS1 = m1s[3:0] ^ injSum;
  assign ovfS1 = m1s[4] ^ injOvf;
  assign sumU2 = m2u[3:0] ^ injSum;
  assign ovfU2 = m2u[4] ^ injOvf;

  logic       busy0, pulse0, fail0;
  logic [7:0] pass0, err0;
  logic [4:0] fexp0, fgot0;
  logic       busy1, pulse1, fail1;
  logic [7:0] pass1, err1;
  logic [4:0] fexp1, fgot1;
  logic       busy2, pulse2, fail2;
  logic [7:0] pass2, err2;
  logic [4:0] fexp2, fgot2;
  logic       busy3, pulse3, fail3;
  logic [7:0] pass3, err3;
  logic [4:0] fexp3, fgot3;
  logic       busy4, pulse4, fail4;
  logic [3:0] pass4, err4;
  logic [4:0] fexp4, fgot4;

  adder_checker #(.WIDTH(4), .LAT(1), .OVF_MODE(0), .STOP_ON_ERR(0), .CW(8)) u0 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_clr(clr), .i_en(en),
    .i_a(a), .i_b(b), .i_sum(sumU1), .i_overflow(ovfU1),
    .o_busy(busy0), .o_pass_cnt(pass0), .o_err_cnt(err0), .o_err_pulse(pulse0),
    .o_fail(fail0), .o_first_exp(fexp0), .o_first_got(fgot0));

  adder_checker #(.WIDTH(4), .LAT(1), .OVF_MODE(1), .STOP_ON_ERR(0), .CW(8)) u1 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_clr(clr), .i_en(en),
    .i_a(a), .i_b(b), .i_sum(sumS1), .i_overflow(ovfS1),
    .o_busy(busy1), .o_pass_cnt(pass1), .o_err_cnt(err1), .o_err_pulse(pulse1),
    .o_fail(fail1), .o_first_exp(fexp1), .o_first_got(fgot1));

  adder_checker #(.WIDTH(4), .LAT(1), .OVF_MODE(0), .STOP_ON_ERR(1), .CW(8)) u2 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_clr(clr), .i_en(en),
    .i_a(a), .i_b(b), .i_sum(sumU1), .i_overflow(ovfU1),
    .o_busy(busy2), .o_pass_cnt(pass2), .o_err_cnt(err2), .o_err_pulse(pulse2),
    .o_fail(fail2), .o_first_exp(fexp2), .o_first_got(fgot2));

  adder_checker #(.WIDTH(4), .LAT(2), .OVF_MODE(0), .STOP_ON_ERR(0), .CW(8)) u3 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_clr(clr), .i_en(en),
    .i_a(a), .i_b(b), .i_sum(sumU2), .i_overflow(ovfU2),
    .o_busy(busy3), .o_pass_cnt(pass3), .o_err_cnt(err3), .o_err_pulse(pulse3),
    .o_fail(fail3), .o_first_exp(fexp3), .o_first_got(fgot3));

  adder_checker #(.WIDTH(4), .LAT(1), .OVF_MODE(0), .STOP_ON_ERR(0), .CW(4)) u4 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_clr(clr), .i_en(en),
    .i_a(a), .i_b(b), .i_sum(sumU1), .i_overflow(ovfU1),
    .o_busy(busy4), .o_pass_cnt(pass4), .o_err_cnt(err4), .o_err_pulse(pulse4),
    .o_fail(fail4), .o_first_exp(fexp4), .o_first_got(fgot4));

  // Drive one cycle of stimulus; injection corrupts the result of the op sampled one edge earlier.
  task automatic applyStimulus(input logic e, input logic [3:0] aa, input logic [3:0] bb,
                               input logic [3:0] is, input logic io);
    en     = e;
    a      = aa;
    b      = bb;
    injSum = is;
    injOvf = io;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    start = 1'b0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    clr = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] injSum;
    logic       injOvf;
    logic [7:0] expPass;
    logic [7:0] expErr;
    logic       expPulse;
    logic       expFail;
    logic [4:0] expFirstExp;
    logic [4:0] expFirstGot;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{4'hF, 4'h1, 4'h0, 1'b0, 8'd9,  8'd0, 1'b0, 1'b0, 5'h00, 5'h00};
    vecs[1] = '{4'hF, 4'h1, 4'h0, 1'b1, 8'd9,  8'd1, 1'b1, 1'b1, 5'h10, 5'h00};
    vecs[2] = '{4'h5, 4'h6, 4'h1, 1'b0, 8'd9,  8'd2, 1'b1, 1'b1, 5'h10, 5'h00};
    vecs[3] = '{4'h8, 4'h8, 4'h0, 1'b0, 8'd10, 8'd2, 1'b0, 1'b1, 5'h10, 5'h00};
    vecs[4] = '{4'h7, 4'h9, 4'h8, 1'b0, 8'd10, 8'd3, 1'b1, 1'b1, 5'h10, 5'h00};

    // Reset state.
    #12;
    checkOutput("rst busy", 32'(busy0), 32'd0);
    checkOutput("rst pass", 32'(pass0), 32'd0);
    checkOutput("rst err", 32'(err0), 32'd0);
    checkOutput("rst pulse", 32'(pulse0), 32'd0);
    checkOutput("rst fail", 32'(fail0), 32'd0);
    checkOutput("rst first_exp", 32'(fexp0), 32'd0);
    checkOutput("rst first_got", 32'(fgot0), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Eight back-to-back passing ops.
    pulseStart();
    checkOutput("start busy", 32'(busy0), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'h3, 4'h4, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("t1 pass", 32'(pass0), 32'd8);
    checkOutput("t1 err", 32'(err0), 32'd0);
    checkOutput("t1 fail", 32'(fail0), 32'd0);
    checkOutput("t1 signed pass", 32'(pass1), 32'd8);

    // Table: one op, then a bubble carrying the injection for that op.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, 4'h0, 1'b0);
      applyStimulus(1'b0, 4'h0, 4'h0, vecs[i].injSum, vecs[i].injOvf);
      checkOutput($sformatf("vec%0d pass", i), 32'(pass0), 32'(vecs[i].expPass));
      checkOutput($sformatf("vec%0d err", i), 32'(err0), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d pulse", i), 32'(pulse0), 32'(vecs[i].expPulse));
      checkOutput($sformatf("vec%0d fail", i), 32'(fail0), 32'(vecs[i].expFail));
      checkOutput($sformatf("vec%0d first_exp", i), 32'(fexp0), 32'(vecs[i].expFirstExp));
      checkOutput($sformatf("vec%0d first_got", i), 32'(fgot0), 32'(vecs[i].expFirstGot));
    end
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("pulse drops", 32'(pulse0), 32'd0);

    // Signed overflow mode: 7+1 and 8+8 pass, then a corrupted 7+1 exposes {1,8}.
    pulseClr();
    pulseStart();
    applyStimulus(1'b1, 4'h7, 4'h1, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h8, 4'h8, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h7, 4'h1, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'hF, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("t3 pass", 32'(pass1), 32'd2);
    checkOutput("t3 err", 32'(err1), 32'd1);
    checkOutput("t3 first_exp", 32'(fexp1), 32'h18);
    checkOutput("t3 first_got", 32'(fgot1), 32'h17);

    // Stop on error: third op corrupted, later ops must not count.
    pulseClr();
    pulseStart();
    applyStimulus(1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h2, 4'h2, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h3, 4'h3, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h4, 4'h4, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h5, 4'h5, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h6, 4'h6, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("t4 pass", 32'(pass2), 32'd2);
    checkOutput("t4 err", 32'(err2), 32'd1);
    checkOutput("t4 busy", 32'(busy2), 32'd0);
    checkOutput("t4 fail", 32'(fail2), 32'd1);
    pulseStart();
    checkOutput("t4 start in halt", 32'(busy2), 32'd0);
    pulseClr();
    checkOutput("t4 clr pass", 32'(pass2), 32'd0);
    checkOutput("t4 clr err", 32'(err2), 32'd0);
    checkOutput("t4 clr fail", 32'(fail2), 32'd0);
    pulseStart();
    checkOutput("t4 restart busy", 32'(busy2), 32'd1);

    // Clr, Start and a mismatch on the same edge.
    applyStimulus(1'b1, 4'h2, 4'h3, 4'h0, 1'b0);
    clr = 1'b1;
    start = 1'b1;
    applyStimulus(1'b1, 4'h1, 4'h1, 4'h1, 1'b0);
    clr = 1'b0;
    start = 1'b0;
    checkOutput("t5 clr err", 32'(err0), 32'd0);
    checkOutput("t5 clr fail", 32'(fail0), 32'd0);
    checkOutput("t5 clr busy", 32'(busy0), 32'd0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("t5 clr pulse", 32'(pulse0), 32'd0);

    // Reset with two entries in flight on the LAT=2 checker.
    pulseStart();
    applyStimulus(1'b1, 4'h1, 4'h2, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h3, 4'h4, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h5, 4'h6, 4'h0, 1'b0);
    checkOutput("t5 lat2 pass", 32'(pass3), 32'd1);
    rstN = 1'b0;
    #2;
    checkOutput("t5 rst pass", 32'(pass3), 32'd0);
    checkOutput("t5 rst busy", 32'(busy3), 32'd0);
    checkOutput("t5 rst err", 32'(err3), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h1, 4'h1, 4'h0, 1'b1);
    checkOutput("t5 post pass", 32'(pass3), 32'd0);
    checkOutput("t5 post err", 32'(err3), 32'd0);
    checkOutput("t5 post busy", 32'(busy3), 32'd0);

    // Saturation of a 4-bit pass counter.
    pulseStart();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'h1, 4'h1, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("t6 sat pass", 32'(pass4), 32'hF);
    checkOutput("t6 sat err", 32'(err4), 32'd0);
    checkOutput("t6 wide pass", 32'(pass0), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_checker.md
Name: adder_checker

Overview:
- Sits at the receiving end of the adder's Sum/Overflow interface.
- Taps the same A/B/En stimulus presented to the adder and computes the expected result internally.
- Delays that expected result to line up with the adder's registered output, compares it against the adder's Sum/Overflow, and counts passes and errors.
- Captures the first mismatch for debug; optionally halts comparison on the first error.

Parameters:
- WIDTH, 4: operand/Sum width in bits.
- LAT, 1: adder latency in clock edges from En-sampled to Sum valid; legal range 1..4.
- OVF_MODE, 0: 0 = Overflow is unsigned carry-out; 1 = Overflow is signed two's-complement overflow.
- STOP_ON_ERR, 0: 1 = enter HALT on the first mismatch.
- CW, 8: pass/error counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; IDLE -> RUN.
- Clr  in  1  synchronous clear of counters, capture registers, pipeline and state.
- En  in  1  adder enable, same net as the adder's En.
- A  in  WIDTH  adder operand A.
- B  in  WIDTH  adder operand B.
- Sum  in  WIDTH  adder result.
- Overflow  in  1  adder overflow flag.
- Busy  out  1  state == RUN.
- Pass_cnt  out  CW  matched comparisons; saturates at all-ones.
- Err_cnt  out  CW  mismatched comparisons; saturates at all-ones.
- Err_pulse  out  1  high for one cycle on each mismatch.
- Fail  out  1  sticky; set on first mismatch.
- First_exp  out  WIDTH+1  {exp_ovf, exp_sum} at first mismatch.
- First_got  out  WIDTH+1  {Overflow, Sum} at first mismatch.

Behaviour:
- Reset (Rst_n=0, async): state = IDLE, all pipeline valids = 0, and all outputs = 0.
- States:
  - IDLE -> RUN on Start.
  - RUN -> HALT on a mismatch when STOP_ON_ERR=1.
  - RUN/HALT -> IDLE on Clr.
  - HALT holds until Clr.
- Expected-value computation, per edge, when state == RUN and En == 1:
  - Push {valid=1, exp_sum, exp_ovf} into stage 0; otherwise push valid=0.
  - exp_sum = (A+B) mod 2^WIDTH.
  - exp_ovf = carry out of the (WIDTH+1)-bit sum if OVF_MODE=0.
  - exp_ovf = (A[MSB]==B[MSB]) && (exp_sum[MSB]!=A[MSB]) if OVF_MODE=1.
- Pipeline: LAT stages, shifting every edge. Compare at the edge where stage LAT-1 holds valid, using the Sum/Overflow sampled at that edge.
  - Example, LAT=1: operands sampled at edge k are checked against Sum at edge k+1.
- Compare outcomes:
  - Match: Pass_cnt += 1.
  - Mismatch: Err_cnt += 1, Err_pulse = 1 the next cycle.
  - On the first mismatch only: Fail <= 1, and First_exp/First_got are loaded.
- In IDLE and HALT no new entries are pushed. In-flight entries still drain, but their comparisons are discarded (no counting).
- Both counters saturate; they never wrap.
- Clr has priority over Start, compare and push in the same cycle. Start while in RUN/HALT is ignored.
- A mismatch on the same edge as Clr is not counted and does not set Fail.
- Reset mid-operation discards all in-flight entries.
- En toggling every cycle is legal; each valid entry is checked independently.

Decomposition:
- Package adder_chk_pkg:
  - State encoding (IDLE=2'b00, RUN=2'b01, HALT=2'b10).
  - Default WIDTH and CW constants.
  - OVF_MODE encodings.
- Sub-module adder_ref_pipe:
  - Computes exp_sum/exp_ovf.
  - Holds the LAT-deep valid/data shift register, with async reset.
- The top level contains the FSM, counters and capture logic.

Test Plan:
1. Reset, Start, then 8 enabled ops with a correct-model DUT, LAT=1, A=3, B=4 -> Pass_cnt=8, Err_cnt=0, Fail=0.
2. A=4'hF, B=4'h1, OVF_MODE=0, DUT reports Sum=0, Overflow=1 -> pass. Same operands with a forced Overflow=0 -> Err_cnt=1, Fail=1, First_exp=5'h10, First_got=5'h00.
3. OVF_MODE=1, A=4'h7, B=4'h1 -> exp {1,4'h8}. A=4'h8, B=4'h8 -> exp {1,4'h0}. Both pass against a correct DUT.
4. STOP_ON_ERR=1: inject Sum error on the 3rd op -> Err_cnt=1, state HALT, Busy=0, later ops not counted. Clr -> IDLE with counters 0.
5. Clr and a mismatch on the same edge -> Err_cnt stays 0, Fail=0. Assert Rst_n low mid-RUN with 2 entries in flight (LAT=2) -> all outputs 0, no counts after release.
6. CW=4, 20 passing ops -> Pass_cnt saturates at 4'hF.
